// File: rtl/counter_snapshot_serializer.sv
// Snapshot a wide counter and stream it LS chunk first over valid/ready.
// Define COUNTER_SNAPSHOT_SERIALIZER_PARITY_EN to add the out_parity output.
module counter_snapshot_serializer #(
  parameter int WIDTH = 129,
  parameter int CHUNK = 32,
  localparam int NUM_WORDS = (WIDTH + CHUNK - 1) / CHUNK,
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             snap_req,
  output logic             busy,
  output logic [CHUNK-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [IDX_W-1:0] out_index,
  output logic [7:0]       drop_cnt
`ifdef COUNTER_SNAPSHOT_SERIALIZER_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int SW = NUM_WORDS * CHUNK;
  localparam int SLOTS = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t           state;
  logic [SW-1:0]    shadow;
  logic [SW-1:0]    ext;
  logic [CHUNK-1:0] words [SLOTS];
  logic [IDX_W-1:0] nxt_idx;
  logic [CHUNK-1:0] nxt_data;
  logic             hs;
  logic             final_hs;
  logic             cap;
  logic             adv;
  logic             fin;

  always_comb begin
    ext = '0;
    ext[WIDTH-1:0] = count_in;
  end

  // Pad to a power of two so any index value reads a defined zero word.
  always_comb begin
    for (int i = 0; i < SLOTS; i++) words[i] = '0;
    for (int i = 0; i < NUM_WORDS; i++) words[i] = shadow[i*CHUNK +: CHUNK];
  end

  assign nxt_idx  = out_index + IDX_W'(1);
  assign hs       = out_valid && out_ready;
  assign final_hs = hs && (out_index == LAST);
  assign cap      = snap_req && ((state == IDLE) || final_hs);
  assign adv      = hs && (out_index != LAST);
  assign fin      = final_hs && !snap_req;
  assign nxt_data = cap ? ext[CHUNK-1:0] : words[nxt_idx];
  assign busy     = (state == SEND);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      shadow    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_index <= '0;
      drop_cnt  <= '0;
    end else begin
      if (cap) begin
        state     <= SEND;
        shadow    <= ext;
        out_data  <= nxt_data;
        out_valid <= 1'b1;
        out_index <= '0;
        out_last  <= (LAST == '0);
      end else if (adv) begin
        out_data  <= nxt_data;
        out_index <= nxt_idx;
        out_last  <= (nxt_idx == LAST);
      end else if (fin) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_index <= '0;
      end
      // Requests that cannot start a new snapshot are counted, not queued.
      if (snap_req && (state == SEND) && !cap && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef COUNTER_SNAPSHOT_SERIALIZER_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset) out_parity <= 1'b0;
    else if (cap || adv) out_parity <= ^nxt_data;
  end
`endif

endmodule

// File: tb/tb_counter_snapshot_serializer.sv
// Randomized + directed bench for counter_snapshot_serializer.
// Reference model tracks the snapshot as a number and slices it by shifting.
module tb_counter_snapshot_serializer;

  localparam int W  = 129;
  localparam int C  = 32;
  localparam int NW = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] count_in;
  logic         snap_req;
  logic         busy;
  logic [C-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [2:0]   out_index;
  logic [7:0]   drop_cnt;
`ifdef COUNTER_SNAPSHOT_SERIALIZER_PARITY_EN
  logic         out_parity;
`endif

  counter_snapshot_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .snap_req  (snap_req),
    .busy      (busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_index (out_index),
    .drop_cnt  (drop_cnt)
`ifdef COUNTER_SNAPSHOT_SERIALIZER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit           m_busy = 0;
  int           m_idx  = 0;
  int           m_drop = 0;
  logic [159:0] m_snap = '0;

  localparam logic [W-1:0] V1 =
    129'h1_DEADBEEF_01234567_89ABCDEF_FEDCBA98;

  task automatic chk(input string tag,
                     input logic [159:0] obs,
                     input logic [159:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mword(input int i);
    logic [159:0] t;
    t = m_snap >> (i * C);
    return t[31:0];
  endfunction

  function automatic logic [W-1:0] rnd_count();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic model(input logic r, input logic s,
                       input logic rd, input logic [W-1:0] c);
    bit hs;
    bit last_hs;
    if (!r) begin
      m_busy = 0;
      m_idx  = 0;
      m_drop = 0;
    end else if (!m_busy) begin
      if (s) begin
        m_snap = 160'(c);
        m_busy = 1;
        m_idx  = 0;
      end
    end else begin
      hs = rd;
      last_hs = hs && (m_idx == NW - 1);
      if (s && !last_hs && m_drop < 255) m_drop++;
      if (last_hs) begin
        if (s) begin
          m_snap = 160'(c);
          m_idx  = 0;
        end else begin
          m_busy = 0;
        end
      end else if (hs) begin
        m_idx++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("valid", 160'(out_valid), 160'(m_busy));
    chk("busy", 160'(busy), 160'(m_busy));
    chk("drop", 160'(drop_cnt), 160'(m_drop));
    if (m_busy) begin
      chk("index", 160'(out_index), 160'(m_idx));
      chk("data", 160'(out_data), 160'(mword(m_idx)));
      chk("last", 160'(out_last), 160'(m_idx == NW - 1));
`ifdef COUNTER_SNAPSHOT_SERIALIZER_PARITY_EN
      chk("parity", 160'(out_parity),
          160'($countones(mword(m_idx)) % 2));
`endif
    end else begin
      chk("last_idle", 160'(out_last), 160'(0));
    end
  endtask

  task automatic cyc(input logic r, input logic s,
                     input logic rd, input logic [W-1:0] c);
    reset     = r;
    snap_req  = s;
    out_ready = rd;
    count_in  = c;
    model(r, s, rd, c);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    reset = 1'b0;
    snap_req = 1'b0;
    out_ready = 1'b0;
    count_in = '0;
    @(negedge clk);

    // reset state
    cyc(0, 1, 1, rnd_count());
    chk("rst_data", 160'(out_data), 160'(0));
    chk("rst_index", 160'(out_index), 160'(0));
    chk("rst_last", 160'(out_last), 160'(0));

    // full stream, sink always ready
    cyc(1, 1, 1, V1);
    chk("w0", 160'(out_data), 160'(32'hFEDCBA98));
`ifdef COUNTER_SNAPSHOT_SERIALIZER_PARITY_EN
    chk("par_w0", 160'(out_parity), 160'(0));
`endif
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, rnd_count());
    chk("w4", 160'(out_data), 160'(32'h00000001));
    chk("w4_last", 160'(out_last), 160'(1));
`ifdef COUNTER_SNAPSHOT_SERIALIZER_PARITY_EN
    chk("par_w4", 160'(out_parity), 160'(1));
`endif
    cyc(1, 0, 1, rnd_count());
    chk("done_valid", 160'(out_valid), 160'(0));
    chk("done_busy", 160'(busy), 160'(0));

    // stall at word 2 while the counter moves
    cyc(1, 1, 1, V1);
    cyc(1, 0, 1, rnd_count());
    cyc(1, 0, 1, rnd_count());
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, rnd_count());
      chk("stall_data", 160'(out_data), 160'(32'h01234567));
      chk("stall_valid", 160'(out_valid), 160'(1));
    end
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, rnd_count());

    // drop counter saturation
    cyc(1, 1, 0, rnd_count());
    for (int i = 0; i < 300; i++) cyc(1, 1, 0, rnd_count());
    chk("drop_sat", 160'(drop_cnt), 160'(255));

    // back-to-back capture on final handshake
    cyc(0, 0, 0, rnd_count());
    cyc(1, 1, 0, V1);
    cyc(1, 1, 0, rnd_count());
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, rnd_count());
    cyc(1, 1, 1, 129'h5);
    chk("b2b_valid", 160'(out_valid), 160'(1));
    chk("b2b_index", 160'(out_index), 160'(0));
    chk("b2b_data", 160'(out_data), 160'(5));
    chk("b2b_drop", 160'(drop_cnt), 160'(1));

    // reset mid-stream at word 3
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, rnd_count());
    chk("pre_rst_idx", 160'(out_index), 160'(3));
    cyc(0, 1, 0, rnd_count());
    chk("mid_rst_valid", 160'(out_valid), 160'(0));
    chk("mid_rst_index", 160'(out_index), 160'(0));
    chk("mid_rst_drop", 160'(drop_cnt), 160'(0));
    cyc(1, 1, 1, V1);
    chk("restart_w0", 160'(out_data), 160'(32'hFEDCBA98));

    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)),
          rnd_count());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_snapshot_serializer.md
Name: counter_snapshot_serializer

Overview:
- Downstream consumer of the wide free-running counter.
- On request, captures a coherent snapshot of the WIDTH-bit count and streams it out as CHUNK-bit words over a valid/ready interface, least-significant chunk first.
- Used to export wide counter values over a narrow bus without tearing.

Parameters:
- WIDTH, 129, width of the counter input; legal range 1 and up.
- CHUNK, 32, output word width; legal range 1..WIDTH.
- Derived localparam NUM_WORDS = ceil(WIDTH/CHUNK), 5 at defaults.
- Derived localparam IDX_W = max(1, clog2(NUM_WORDS)).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0 at a clk rising edge).
- count_in  input  WIDTH  live counter value to be snapshotted.
- snap_req  input  1  single-cycle capture request.
- busy  output  1  high while a snapshot is held or streaming.
- out_data  output  CHUNK  current word.
- out_valid  output  1  word valid.
- out_ready  input  1  sink accepts word.
- out_last  output  1  high with final word of a snapshot.
- out_index  output  IDX_W  index of current word, 0..NUM_WORDS-1.
- drop_cnt  output  8  saturating count of rejected snap_req.

Behaviour:
- Reset (reset==0 at posedge): state IDLE; out_valid=0, out_data=0, out_last=0, out_index=0, busy=0, drop_cnt=0. Reset overrides all other events.
- FSM has two states, IDLE and SEND; busy = (state==SEND).
- IDLE + snap_req=1:
  - Register count_in into a shadow register, zero-extended to NUM_WORDS*CHUNK bits.
  - Go to SEND with out_index=0.
  - out_valid rises the cycle after snap_req (latency 1).
- out_data = shadow[out_index*CHUNK +: CHUNK], registered. Bits above WIDTH read 0.
- SEND: out_valid stays high. out_data, out_index and out_last are stable until a handshake (out_valid&&out_ready); there is no valid retraction.
- Handshake on word i < NUM_WORDS-1: word i+1 is presented the next cycle with no bubble.
- Handshake on the final word:
  - snap_req=0: return to IDLE; out_valid=0 and out_last=0 next cycle.
  - snap_req=1 in the same cycle: capture the new count_in and present word 0 next cycle. out_valid stays high. Not counted as a drop.
- out_last = out_valid && (out_index==NUM_WORDS-1).
- snap_req in SEND, except the final-handshake case above: ignored. drop_cnt increments and saturates at 255 (no wrap).
- Changes on count_in after capture never affect the streamed words.
- Reset low mid-stream: the snapshot is abandoned and outputs take reset values next cycle. Any snap_req that cycle is ignored.
- NUM_WORDS==1: every word is both first and last.

Optional Feature:
- Macro: COUNTER_SNAPSHOT_SERIALIZER_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR of out_data, registered alongside out_data (even parity over word + bit).
  - Resets to 0.
  - Valid only when out_valid=1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then snap_req with count_in=129'h1_DEADBEEF_01234567_89ABCDEF_FEDCBA98, out_ready=1 -> starting 1 cycle later, words FEDCBA98, 89ABCDEF, 01234567, DEADBEEF, 00000001 on consecutive cycles. out_index 0..4; out_last only on the 5th; out_valid=0 and busy=0 after.
- Same snapshot with out_ready=0 for 3 cycles while out_index=2 -> out_data holds 01234567 with out_valid=1 throughout. No word is skipped or repeated; count_in changes meanwhile have no effect.
- snap_req held high for 300 cycles while out_ready=0 in SEND -> drop_cnt reaches 255 and stays at 255.
- snap_req=1 coincident with the final-word handshake, count_in=129'h5 -> next cycle out_valid=1, out_index=0, out_data=00000005, drop_cnt unchanged.
- reset driven low for one cycle while out_index=3 -> next cycle out_valid=0, busy=0, out_index=0, drop_cnt=0. A following snap_req streams from word 0.
- Macro defined, first test's stimulus -> out_parity=0 for FEDCBA98 (20 ones) and 1 for 00000001. Macro undefined -> the build has no out_parity port.
